serial_add_ctrl: RTL
====================

# serial_add_ctrl

Bit-serial adder controller that time-shares a single one-bit full-adder cell to add two WIDTH-bit operands over WIDTH clock cycles. It sits beside the gate-level full adder in the arithmetic library as the first sequenced user of that cell. It trades latency for area: one adder cell, two shift registers and a small FSM. A start/done handshake lets a host issue one addition at a time.

## Interface
- WIDTH, 8, operand and result width in bits; legal range 2..32
- clk  input  1  rising-edge clock; single clock domain
- rst_n  input  1  reset, synchronous, active-low
- start  input  1  request an addition; sampled only in IDLE
- a  input  WIDTH  operand A; captured on the accepting edge
- b  input  WIDTH  operand B; captured on the accepting edge
- cin  input  1  carry-in; captured on the accepting edge
- sub  input  1  subtract select; present only with SERIAL_ADD_SUB_EN
- busy  output  1  high while bits are being processed
- done  output  1  one-cycle pulse when sum/cout are final
- sum  output  WIDTH  result; held until the next accepted start
- cout  output  1  carry-out of the MSB; held with sum

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE, start=1: latch a into shift register A and b into shift register B, set carry to cin, clear sum, clear bit counter, go to RUN.
- IDLE, start=0: stay in IDLE; sum and cout hold their values.
- RUN, each edge:
  - The full-adder cell adds A[0], B[0] and carry.
  - Shift the sum bit into sum at the MSB (sum shifts right).
  - Shift A and B right by one.
  - Carry takes the cell's carry-out.
  - Increment the counter.
- RUN exits to DONE on the edge that processes bit WIDTH-1; cout then takes that edge's final carry-out.
- DONE lasts exactly one cycle, then returns to IDLE.
- start is ignored in RUN and DONE. There is no queueing, and a start held high through DONE is not accepted until IDLE.
- All arithmetic is modulo 2^WIDTH; cout is bit WIDTH of a + b + cin.
- Counter width is $clog2(WIDTH). Bit WIDTH-1 is detected by count == WIDTH-1, so it never wraps.

## Timing
- Reset values: state IDLE, busy 0, done 0, sum 0, cout 0, carry 0, counter 0.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Start accepted at edge k:
  - busy goes high after edge k.
  - Bit i is processed at edge k+1+i.
  - busy goes low and done goes high after edge k+WIDTH.
  - done goes low after edge k+WIDTH+1.
- The earliest next accept is edge k+WIDTH+1, so throughput is one addition per WIDTH+1 cycles.
- sum and cout are valid from the done cycle until the next accepting edge. They are mid-shift (not valid) while busy=1.
- rst_n=0 at any edge, including mid-RUN or during DONE, aborts the operation and forces all reset values on that edge; no done pulse is produced.

## Configuration
- SERIAL_ADD_SUB_EN defined:
  - The sub port exists and is captured with the operands.
  - sub=1 loads ~b into B and forces carry to 1, ignoring cin.
  - Result is a - b mod 2^WIDTH; cout=1 means no borrow.
  - sub=0 behaves as plain add.
- Macro undefined: the sub port is absent; addition only.

## Structure
- Package serial_add_pkg holds:
  - the state encoding constants S_IDLE, S_RUN, S_DONE (2-bit);
  - the default WIDTH constant.
- One sub-module, fa_cell: a combinational one-bit full adder with ports a, b, cin, s, cout. It is instantiated once; no other arithmetic appears in the controller.

## Test plan
- WIDTH=8; a=0x00, b=0x00, cin=0 -> sum 0x00, cout 0; done rises exactly 8 cycles after busy rises; done width 1 cycle.
- a=0xFF, b=0x01, cin=0 -> sum 0x00, cout 1; a=0xA5, b=0x5A, cin=1 -> sum 0x00, cout 1.
- Start pulsed again during RUN with a=0x01, b=0x01 -> ignored; the in-flight result (0x10+0x20=0x30) completes unchanged.
- rst_n low for one edge at the 4th RUN cycle -> busy, done, sum, cout all 0 next cycle; no done pulse follows; a new start then completes normally.
- Exhaustive sweep of all 65536 a/b pairs with cin=0 and cin=1, back-to-back starts -> every result matches a+b+cin; the accept interval is exactly 9 cycles.
- With SERIAL_ADD_SUB_EN: 0x10-0x01 -> 0x0F, cout 1; 0x01-0x02 -> 0xFF, cout 0; sub=1 with cin=0 gives the same results as with cin=1.

Source files
------------

// File: rtl/serial_add_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// serial_add_pkg
// Shared definitions for the bit-serial adder controller:
//   - state_t      : FSM state encoding (S_IDLE, S_RUN, S_DONE), 2 bits
//   - DEFAULT_WIDTH: default operand/result width
// Optional feature macro used by the rest of the slice: SERIAL_ADD_SUB_EN
// ---------------------------------------------------------------------------
package serial_add_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_add_ctrl_if.sv
// ---------------------------------------------------------------------------
// serial_add_ctrl_if
// Host-side handshake and operand/result bundle for serial_add_ctrl.
//   start, a, b, cin (, sub) : host -> controller request
//   busy, done, sum, cout    : controller -> host status/result
// Modports: master (host side), slave (controller side).
// Macro SERIAL_ADD_SUB_EN adds the sub (subtract select) signal.
// ---------------------------------------------------------------------------
interface serial_add_ctrl_if
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) ();

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef SERIAL_ADD_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

`ifdef SERIAL_ADD_SUB_EN
    modport master (output start, a, b, cin, sub, input busy, done, sum, cout);
    modport slave  (input start, a, b, cin, sub, output busy, done, sum, cout);
`else
    modport master (output start, a, b, cin, input busy, done, sum, cout);
    modport slave  (input start, a, b, cin, output busy, done, sum, cout);
`endif

endinterface

// File: rtl/serial_add_ctrl_fa_cell.sv
// ---------------------------------------------------------------------------
// fa_cell
// Combinational one-bit full adder.
//   a, b, cin : addend bits and carry-in
//   s         : sum bit
//   cout      : carry-out
// ---------------------------------------------------------------------------
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// serial_add_ctrl
// Bit-serial adder: one fa_cell is time-shared over WIDTH cycles to add two
// WIDTH-bit operands. One addition at a time via a start/done handshake.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : serial_add_ctrl_if.slave (start/a/b/cin[/sub] in,
//           busy/done/sum/cout out; all outputs registered)
// Macro SERIAL_ADD_SUB_EN enables subtraction (sub=1 -> a - b).
// ---------------------------------------------------------------------------
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_add_ctrl_if.slave   bus
);

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [WIDTH-1:0] b_load;
    logic             carry_load;
    logic             fa_s;
    logic             fa_co;

    fa_cell u_fa (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .cin  (carry_q),
        .s    (fa_s),
        .cout (fa_co)
    );

    // Subtraction is a + ~b + 1, so it only changes what gets loaded.
    always_comb begin
`ifdef SERIAL_ADD_SUB_EN
        b_load     = bus.sub ? ~bus.b : bus.b;
        carry_load = bus.sub ? 1'b1   : bus.cin;
`else
        b_load     = bus.b;
        carry_load = bus.cin;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.start) state_d = S_RUN;
            S_RUN:   if (cnt_q == LAST) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath: load on accept, then shift one bit per RUN edge. The sum
    // fills from the MSB so bit 0 lands in place after WIDTH shifts.
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = b_load;
                    carry_d = carry_load;
                    sum_d   = '0;
                    cnt_d   = '0;
                end
            end
            S_RUN: begin
                sum_d   = {fa_s, sum_q[WIDTH-1:1]};
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                carry_d = fa_co;
                if (cnt_q == LAST) begin
                    cout_d = fa_co;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: ;
        endcase
    end

    assign bus.busy = (state_q == S_RUN);
    assign bus.done = (state_q == S_DONE);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;

endmodule
